// File: rtl/mantissa_sub_pipe_pkg.sv
// Shared constants and types for the mantissa subtract pipeline.
package mantissa_sub_pipe_pkg;
  localparam int MANT_W = 24;
  typedef logic [MANT_W-1:0] mant_t;
endpackage

// File: rtl/mantissa_sub_pipe_if.sv
// Upstream operand handshake and downstream result handshake.
interface mantissa_sub_pipe_if #(parameter int WIDTH = mantissa_sub_pipe_pkg::MANT_W);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] diff;
  logic             swap;
  logic             zero;

  modport master (
    output req_valid, a, b, rsp_ready,
    input  req_ready, rsp_valid, diff, swap, zero
  );

  modport slave (
    input  req_valid, a, b, rsp_ready,
    output req_ready, rsp_valid, diff, swap, zero
  );
endinterface

// File: rtl/mantissa_sub_pipe_borrow_lookahead_4.sv
// 4-bit borrow lookahead cell and the WIDTH-bit lookahead subtractor built from it.

module borrow_lookahead_4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       bin,
  output logic       G,
  output logic       P,
  output logic [4:0] borrow
);
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;

  // every borrow is a flat sum of products, no ripple inside the group
  assign borrow[0] = bin;
  assign borrow[1] = g[0] | (p[0] & bin);
  assign borrow[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign borrow[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
  assign borrow[4] = G | (P & bin);
endmodule

// x - y with borrow-in 0; bout=1 means y > x.
module mantissa_sub_cla #(parameter int WIDTH = 24) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] d,
  output logic             bout
);
  localparam int NG = WIDTH / 4;    // bit groups
  localparam int NB = (NG + 3) / 4; // super-groups of four bit groups

  logic [WIDTH-1:0]  g, p, bvec;
  logic [NG-1:0]     gg, gp, gbin, grp_bout;
  logic [NB*4-1:0]   gg_pad, gp_pad;
  logic [NB-1:0]     sg, sp;
  logic [NB:0]       sbin;
  logic [NB-1:0][4:0] sb;
  logic              unused_bits;

  assign g = ~x & y;
  assign p = ~(x ^ y);

  generate
    for (genvar i = 0; i < NG; i++) begin : g_grp
      logic [4:0] bb;
      borrow_lookahead_4 u_grp (
        .g(g[4*i +: 4]), .p(p[4*i +: 4]), .bin(gbin[i]),
        .G(gg[i]), .P(gp[i]), .borrow(bb)
      );
      assign bvec[4*i +: 4] = bb[3:0];
      assign grp_bout[i]    = bb[4];
      assign gbin[i]        = sb[i/4][i%4];
    end

    // padding groups are transparent (G=0, P=1) so they never mask a real generate
    for (genvar k = 0; k < NB*4; k++) begin : g_pad
      if (k < NG) begin : g_real
        assign gg_pad[k] = gg[k];
        assign gp_pad[k] = gp[k];
      end else begin : g_fill
        assign gg_pad[k] = 1'b0;
        assign gp_pad[k] = 1'b1;
      end
    end

    for (genvar k = 0; k < NB; k++) begin : g_sup
      borrow_lookahead_4 u_sup (
        .g(gg_pad[4*k +: 4]), .p(gp_pad[4*k +: 4]), .bin(sbin[k]),
        .G(sg[k]), .P(sp[k]), .borrow(sb[k])
      );
      assign sbin[k+1] = sg[k] | (sp[k] & sbin[k]);
    end
  endgenerate

  assign sbin[0] = 1'b0;
  assign d       = x ^ y ^ bvec;
  assign bout    = sbin[NB];

  // group carry-outs are recomputed one level up; keep them visibly consumed
  assign unused_bits = ^{sb, grp_bout};
endmodule

// File: rtl/mantissa_sub_pipe.sv
// Two-stage |A-B| pipeline: stage 1 orders the operands, stage 2 subtracts.
module mantissa_sub_pipe
  import mantissa_sub_pipe_pkg::*;
#(
  parameter int WIDTH = MANT_W
) (
  input logic              clk,
  input logic              rst,
  mantissa_sub_pipe_if.slave bus
);
  generate
    if (WIDTH % 4 != 0) begin : g_bad_width
      $error("mantissa_sub_pipe: WIDTH must be a multiple of 4");
    end
  endgenerate

  logic             s1_v, s1_swap, s1_eq;
  logic [WIDTH-1:0] s1_min, s1_sub;
  logic             adv2, acc, s1_bout;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] unused_s1_diff;
  logic             unused_s2_bout;

  assign adv2          = s1_v & (~bus.rsp_valid | bus.rsp_ready);
  assign bus.req_ready = ~s1_v | adv2;
  assign acc           = bus.req_valid & bus.req_ready;

  mantissa_sub_cla #(.WIDTH(WIDTH)) u_cmp (
    .x(bus.a), .y(bus.b), .d(unused_s1_diff), .bout(s1_bout)
  );

  mantissa_sub_cla #(.WIDTH(WIDTH)) u_sub (
    .x(s1_min), .y(s1_sub), .d(d2), .bout(unused_s2_bout)
  );

  // stage 1: capture ordered operands on accept, empty when handed on
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_swap <= 1'b0;
      s1_eq   <= 1'b0;
      s1_min  <= '0;
      s1_sub  <= '0;
    end else if (acc) begin
      s1_v    <= 1'b1;
      s1_swap <= s1_bout;
      s1_eq   <= (bus.a == bus.b);
      s1_min  <= s1_bout ? bus.b : bus.a;
      s1_sub  <= s1_bout ? bus.a : bus.b;
    end else if (adv2) begin
      s1_v <= 1'b0;
    end
  end

  // stage 2: result register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.diff      <= '0;
      bus.swap      <= 1'b0;
      bus.zero      <= 1'b0;
    end else if (adv2) begin
      bus.rsp_valid <= 1'b1;
      bus.diff      <= d2;
      bus.swap      <= s1_swap;
      bus.zero      <= s1_eq;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mantissa_sub_pipe.sv
// Directed-vector bench for mantissa_sub_pipe.
module tb_mantissa_sub_pipe;
  import mantissa_sub_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mantissa_sub_pipe_if #(.WIDTH(24)) bus ();

  mantissa_sub_pipe #(.WIDTH(24)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t required less", $time);
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // one pair into an empty pipe; returns valid after one and two edges plus outputs
  task automatic op(input mant_t a, input mant_t b, output logic v1, output logic v2,
                    output mant_t d, output logic s, output logic z);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    step();
    bus.req_valid = 1'b0;
    v1 = bus.rsp_valid;
    step();
    v2 = bus.rsp_valid;
    d  = bus.diff;
    s  = bus.swap;
    z  = bus.zero;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.a = 24'h123456;
    bus.b = 24'h000001;
    repeat (3) step();
    checks++;
    if ({bus.rsp_valid, bus.diff, bus.swap, bus.zero} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h s=%b z=%b, expected all zero",
               bus.rsp_valid, bus.diff, bus.swap, bus.zero);
    end
    rst = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", bus.req_ready);
    end
    step();
  endtask

  task automatic test_basic;
    logic v1, v2, s, z;
    mant_t d;
    op(24'd10, 24'd3, v1, v2, d, s, z);
    checks++;
    if ({v1, v2} !== 2'b01) begin
      errors++;
      $display("FAIL latency: got v1=%b v2=%b expected 0 1", v1, v2);
    end
    checks++;
    if ({d, s, z} !== {24'd7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_10_3: got d=%h s=%b z=%b expected 000007 0 0", d, s, z);
    end
    op(24'd3, 24'd10, v1, v2, d, s, z);
    checks++;
    if ({v2, d, s, z} !== {1'b1, 24'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_3_10: got v=%b d=%h s=%b z=%b expected 1 000007 1 0", v2, d, s, z);
    end
    step();
  endtask

  task automatic test_boundary;
    logic v1, v2, s, z;
    mant_t d;
    op(24'h5A5A5A, 24'h5A5A5A, v1, v2, d, s, z);
    checks++;
    if ({v2, d, s, z} !== {1'b1, 24'h000000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL equal: got v=%b d=%h s=%b z=%b expected 1 000000 0 1", v2, d, s, z);
    end
    op(24'hFFFFFF, 24'h000000, v1, v2, d, s, z);
    checks++;
    if ({v2, d, s, z} !== {1'b1, 24'hFFFFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL max_minus_zero: got v=%b d=%h s=%b z=%b expected 1 ffffff 0 0", v2, d, s, z);
    end
    op(24'h800000, 24'h000001, v1, v2, d, s, z);
    checks++;
    if ({v2, d, s, z} !== {1'b1, 24'h7FFFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL borrow_chain: got v=%b d=%h s=%b z=%b expected 1 7fffff 0 0", v2, d, s, z);
    end
    step();
  endtask

  task automatic test_back_to_back;
    mant_t va [8] = '{24'h000010, 24'h000001, 24'h123456, 24'h00FFFF,
                      24'hABCDEF, 24'hFFFFFF, 24'h000000, 24'h400000};
    mant_t vb [8] = '{24'h000001, 24'h000010, 24'h012345, 24'h010000,
                      24'hABCDEF, 24'h000001, 24'hFFFFFF, 24'h3FFFFF};
    mant_t ed [8] = '{24'h00000F, 24'h00000F, 24'h111111, 24'h000001,
                      24'h000000, 24'hFFFFFE, 24'hFFFFFF, 24'h000001};
    logic  es [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic  ez [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 8) begin
        bus.req_valid = 1'b1;
        bus.a = va[c];
        bus.b = vb[c];
        #0;
        checks++;
        if (bus.req_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready[%0d]: got %b expected 1", c, bus.req_ready);
        end
      end else begin
        bus.req_valid = 1'b0;
      end
      step();
      if (c >= 1) begin
        checks++;
        if ({bus.rsp_valid, bus.diff, bus.swap, bus.zero} !== {1'b1, ed[c-1], es[c-1], ez[c-1]}) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got v=%b d=%h s=%b z=%b expected 1 %h %b %b",
                   c-1, bus.rsp_valid, bus.diff, bus.swap, bus.zero, ed[c-1], es[c-1], ez[c-1]);
        end
      end
    end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got valid %b expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_backpressure;
    mant_t pa [4] = '{24'h000100, 24'h000005, 24'h0F0F0F, 24'h777777};
    mant_t pb [4] = '{24'h000001, 24'h000009, 24'h0F0F0F, 24'h111111};
    mant_t pd [4] = '{24'h0000FF, 24'h000004, 24'h000000, 24'h666666};
    logic  ps [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic  pz [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int sent = 0;
    int recv = 0;
    logic acc, cons;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      bus.req_valid = (sent < 4);
      bus.a = (sent < 4) ? pa[sent] : 24'h0;
      bus.b = (sent < 4) ? pb[sent] : 24'h0;
      #0;
      acc = bus.req_valid & bus.req_ready;
      step();
      if (acc) sent++;
      if (c >= 2) begin
        checks++;
        if (bus.req_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready[%0d]: got %b expected 0", c, bus.req_ready);
        end
        checks++;
        if ({bus.rsp_valid, bus.diff, bus.swap, bus.zero} !== {1'b1, pd[0], ps[0], pz[0]}) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%b z=%b expected 1 %h %b %b",
                   c, bus.rsp_valid, bus.diff, bus.swap, bus.zero, pd[0], ps[0], pz[0]);
        end
      end
    end
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 20 && recv < 4; c++) begin
      bus.req_valid = (sent < 4);
      bus.a = (sent < 4) ? pa[sent] : 24'h0;
      bus.b = (sent < 4) ? pb[sent] : 24'h0;
      #0;
      acc  = bus.req_valid & bus.req_ready;
      cons = bus.rsp_valid & bus.rsp_ready;
      if (cons) begin
        checks++;
        if ({bus.diff, bus.swap, bus.zero} !== {pd[recv], ps[recv], pz[recv]}) begin
          errors++;
          $display("FAIL bp_result[%0d]: got d=%h s=%b z=%b expected %h %b %b",
                   recv, bus.diff, bus.swap, bus.zero, pd[recv], ps[recv], pz[recv]);
        end
        recv++;
      end
      step();
      if (acc) sent++;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (recv !== 4) begin
      errors++;
      $display("FAIL bp_count: got %0d results expected 4", recv);
    end
    step();
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_duplicate: got valid %b expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_reset_midflight;
    logic v1, v2, s, z;
    mant_t d;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.a = 24'h000009;
    bus.b = 24'h000002;
    step();
    bus.a = 24'h000002;
    bus.b = 24'h000009;
    step();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.diff, bus.swap, bus.zero, bus.req_ready} !== {1'b0, 24'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midflight_reset: got v=%b d=%h s=%b z=%b r=%b expected 0 000000 0 0 1",
               bus.rsp_valid, bus.diff, bus.swap, bus.zero, bus.req_ready);
    end
    op(24'h000010, 24'h000003, v1, v2, d, s, z);
    checks++;
    if ({v1, v2, d, s, z} !== {1'b0, 1'b1, 24'h00000D, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_result: got v1=%b v2=%b d=%h s=%b z=%b expected 0 1 00000d 0 0",
               v1, v2, d, s, z);
    end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_stale: got valid %b expected 0", bus.rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
